// File: rtl/cw_output_arbiter_pkg.sv
// cw_output_arbiter_pkg: shared router constants, VC encoding and round-robin state
package cw_output_arbiter_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int HOP_MSB = 55;
   localparam int HOP_LSB = 48;
   localparam int VC_BIT = 63;
   localparam int DIR_BIT = 62;
   typedef enum logic {VC_EVEN = 1'b0, VC_ODD = 1'b1} vc_e;
   typedef enum logic {RR_RING = 1'b0, RR_PE = 1'b1} rr_e;
endpackage

// File: rtl/cw_output_arbiter_vc_rr.sv
// cw_output_arbiter_vc_rr: two-requester round-robin feeding a one-entry VC buffer
module cw_output_arbiter_vc_rr #(
   parameter int DATA_WIDTH = cw_output_arbiter_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_ring,
   input  logic                  req_pe,
   input  logic [DATA_WIDTH-1:0] data_ring,
   input  logic [DATA_WIDTH-1:0] data_pe,
   input  logic                  pop,
   output logic                  grant_ring,
   output logic                  grant_pe,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] data
);
   import cw_output_arbiter_pkg::*;
   rr_e rr;
   logic open;
   // no bypass: only a buffer already empty at cycle start may accept
   assign open = !rst && !full;
   assign grant_ring = open && req_ring && (!req_pe || rr == RR_RING);
   assign grant_pe = open && req_pe && (!req_ring || rr == RR_PE);
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
         rr <= RR_RING;
      end else if (grant_ring || grant_pe) begin
         full <= 1'b1;
         data <= grant_ring ? data_ring : data_pe;
         rr <= grant_ring ? RR_PE : RR_RING;
      end else if (pop) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/cw_output_arbiter.sv
// cw_output_arbiter: per-direction output stage; two VC buffers share one link by polarity
module cw_output_arbiter #(
   parameter int DATA_WIDTH = cw_output_arbiter_pkg::DATA_WIDTH,
   parameter int HOP_MSB = cw_output_arbiter_pkg::HOP_MSB,
   parameter int HOP_LSB = cw_output_arbiter_pkg::HOP_LSB
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  polarity,
   input  logic                  req_ring_even,
   input  logic                  req_ring_odd,
   input  logic                  req_pe_even,
   input  logic                  req_pe_odd,
   input  logic [DATA_WIDTH-1:0] data_ring_even,
   input  logic [DATA_WIDTH-1:0] data_ring_odd,
   input  logic [DATA_WIDTH-1:0] data_pe_even,
   input  logic [DATA_WIDTH-1:0] data_pe_odd,
   output logic                  grant_ring_even,
   output logic                  grant_ring_odd,
   output logic                  grant_pe_even,
   output logic                  grant_pe_odd,
   input  logic                  ro,
   output logic                  so,
   output logic [DATA_WIDTH-1:0] dout
);
   import cw_output_arbiter_pkg::*;
   vc_e sel;
   logic full_even, full_odd, send, pop_even, pop_odd;
   logic [DATA_WIDTH-1:0] slot_even, slot_odd, pick, shifted;
   assign sel = vc_e'(polarity);
   assign pick = sel == VC_ODD ? slot_odd : slot_even;
   assign send = ro && (sel == VC_ODD ? full_odd : full_even);
   assign pop_even = send && sel == VC_EVEN;
   assign pop_odd = send && sel == VC_ODD;
   always_comb begin
      shifted = pick;
      shifted[HOP_MSB:HOP_LSB] = pick[HOP_MSB:HOP_LSB] >> 1;
   end
   cw_output_arbiter_vc_rr #(.DATA_WIDTH(DATA_WIDTH)) u_even (
      .clk(clk), .rst(rst), .req_ring(req_ring_even), .req_pe(req_pe_even),
      .data_ring(data_ring_even), .data_pe(data_pe_even), .pop(pop_even),
      .grant_ring(grant_ring_even), .grant_pe(grant_pe_even), .full(full_even), .data(slot_even)
   );
   cw_output_arbiter_vc_rr #(.DATA_WIDTH(DATA_WIDTH)) u_odd (
      .clk(clk), .rst(rst), .req_ring(req_ring_odd), .req_pe(req_pe_odd),
      .data_ring(data_ring_odd), .data_pe(data_pe_odd), .pop(pop_odd),
      .grant_ring(grant_ring_odd), .grant_pe(grant_pe_odd), .full(full_odd), .data(slot_odd)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         so <= 1'b0;
         dout <= '0;
      end else begin
         so <= send;
         if (send) dout <= shifted;
      end
   end
endmodule

// File: tb/tb_cw_output_arbiter.sv
// tb_cw_output_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_cw_output_arbiter;
   logic clk = 1'b0, rst = 1'b1, polarity = 1'b0, ro = 1'b0;
   logic [3:0] rq = '0, gq, last_g = '0;
   logic [63:0] dq [4];
   logic so;
   logic [63:0] dout;
   logic mfull [2];
   logic [63:0] mslot [2];
   logic mpe [2];
   logic mso = 1'b0;
   logic [63:0] mdout = '0;
   int checks = 0, errors = 0;
   bit seq [$];

   cw_output_arbiter dut (
      .clk(clk), .rst(rst), .polarity(polarity),
      .req_ring_even(rq[0]), .req_ring_odd(rq[1]), .req_pe_even(rq[2]), .req_pe_odd(rq[3]),
      .data_ring_even(dq[0]), .data_ring_odd(dq[1]), .data_pe_even(dq[2]), .data_pe_odd(dq[3]),
      .grant_ring_even(gq[0]), .grant_ring_odd(gq[1]), .grant_pe_even(gq[2]), .grant_pe_odd(gq[3]),
      .ro(ro), .so(so), .dout(dout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // hop field is an 8-bit count that halves on each hop
   function automatic logic [63:0] hop(input logic [63:0] d);
      logic [7:0] h;
      h = d[55:48];
      d[55:48] = h / 8'd2;
      return d;
   endfunction

   function automatic logic [3:0] exp_grants();
      logic [3:0] g;
      g = '0;
      for (int v = 0; v < 2; v++)
         if (!rst && !mfull[v]) begin
            if (rq[v] && rq[2+v]) g[mpe[v] ? 2+v : v] = 1'b1;
            else begin
               g[v] = rq[v];
               g[2+v] = rq[2+v];
            end
         end
      return g;
   endfunction

   task automatic step();
      logic [3:0] eg;
      int s;
      #1;
      eg = exp_grants();
      chk("grants", {60'd0, gq}, {60'd0, eg});
      @(posedge clk);
      if (rst) begin
         for (int v = 0; v < 2; v++) begin
            mfull[v] = 1'b0;
            mslot[v] = '0;
            mpe[v] = 1'b0;
         end
         mso = 1'b0;
         mdout = '0;
      end else begin
         s = polarity ? 1 : 0;
         mso = mfull[s] && ro;
         if (mso) begin
            mdout = hop(mslot[s]);
            mfull[s] = 1'b0;
         end
         for (int v = 0; v < 2; v++)
            if (eg[v] || eg[2+v]) begin
               mslot[v] = eg[v] ? dq[v] : dq[2+v];
               mfull[v] = 1'b1;
               mpe[v] = eg[v];
            end
      end
      last_g = eg;
      #1;
      chk("so", {63'd0, so}, {63'd0, mso});
      chk("dout", dout, mdout);
      @(negedge clk);
   endtask

   task automatic drop();
      for (int i = 0; i < 4; i++) if (last_g[i]) rq[i] = 1'b0;
   endtask

   task automatic do_reset();
      rq = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int at, socnt, gcnt;
      logic [63:0] cap;
      for (int i = 0; i < 4; i++) dq[i] = {$urandom, $urandom};
      for (int v = 0; v < 2; v++) begin
         mfull[v] = 1'b0;
         mslot[v] = '0;
         mpe[v] = 1'b0;
      end
      @(negedge clk);
      // reset holds off grants even with a live request
      rq[2] = 1'b1;
      step();
      step();
      #1;
      chk("rst_grants", {60'd0, gq}, 64'd0);
      chk("rst_so", {63'd0, so}, 64'd0);
      chk("rst_dout", dout, 64'd0);
      rst = 1'b0;
      rq[0] = 1'b1;
      #1;
      chk("first_ring_priority", {60'd0, gq}, 64'b0001);
      step();

      // single PE packet with hop shift
      do_reset();
      ro = 1'b1;
      polarity = 1'b0;
      rq[2] = 1'b1;
      dq[2] = 64'h0F0F_0F00_0000_0001;
      #1;
      chk("pe_grant", {60'd0, gq}, 64'b0100);
      step();
      drop();
      at = -1;
      cap = '0;
      for (int i = 0; i < 6; i++) begin
         polarity = ~polarity;
         step();
         if (so && at < 0) begin
            at = i;
            cap = dout;
         end
      end
      chk("pe_send_cycle", 64'(at), 64'd1);
      chk("pe_dout", cap, 64'h0F07_0F00_0000_0001);

      // contention on odd VC alternates ring, pe, ring, pe
      do_reset();
      ro = 1'b1;
      rq[1] = 1'b1;
      rq[3] = 1'b1;
      seq.delete();
      for (int i = 0; i < 24; i++) begin
         polarity = ~polarity;
         step();
         if (last_g[1]) begin
            seq.push_back(1'b1);
            dq[1] = {$urandom, $urandom};
         end else if (last_g[3]) begin
            seq.push_back(1'b0);
            dq[3] = {$urandom, $urandom};
         end
      end
      for (int k = 0; k < 4; k++)
         chk("contention_order", k < seq.size() ? 64'(seq[k]) : 64'd2, (k % 2 == 0) ? 64'd1 : 64'd0);

      // backpressure holds both buffers
      do_reset();
      ro = 1'b0;
      rq[0] = 1'b1;
      rq[3] = 1'b1;
      dq[0] = 64'h1122_3344_5566_7788;
      dq[3] = 64'hAAFF_0000_0000_0001;
      step();
      drop();
      rq[2] = 1'b1;
      socnt = 0;
      gcnt = 0;
      for (int i = 0; i < 10; i++) begin
         polarity = ~polarity;
         step();
         socnt += int'(so);
         gcnt += $countones(last_g);
      end
      chk("bp_so_count", 64'(socnt), 64'd0);
      chk("bp_grant_count", 64'(gcnt), 64'd0);
      rq[2] = 1'b0;
      ro = 1'b1;
      polarity = 1'b0;
      step();
      chk("bp_even_out", dout, 64'h1111_3344_5566_7788);
      polarity = 1'b1;
      step();
      chk("bp_odd_so", {63'd0, so}, 64'd1);
      chk("bp_odd_out", dout, 64'hAA7F_0000_0000_0001);

      // polarity isolation
      do_reset();
      ro = 1'b1;
      polarity = 1'b0;
      rq[1] = 1'b1;
      step();
      drop();
      socnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         socnt += int'(so);
      end
      chk("iso_so_count", 64'(socnt), 64'd0);
      polarity = 1'b1;
      step();
      chk("iso_so", {63'd0, so}, 64'd1);

      // reset mid-operation discards buffers, pending requests win right after
      do_reset();
      ro = 1'b0;
      rq[0] = 1'b1;
      rq[1] = 1'b1;
      step();
      drop();
      rq[2] = 1'b1;
      rq[3] = 1'b1;
      step();
      rst = 1'b1;
      ro = 1'b1;
      polarity = 1'b0;
      step();
      chk("midrst_so", {63'd0, so}, 64'd0);
      rst = 1'b0;
      #1;
      chk("midrst_regrant", {60'd0, gq}, 64'b1100);
      step();
      drop();

      // random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(99) == 0);
         ro = ($urandom_range(3) != 0);
         polarity = ($urandom_range(4) == 0) ? polarity : ~polarity;
         step();
         for (int i = 0; i < 4; i++) begin
            if (last_g[i]) rq[i] = 1'b0;
            if (!rq[i] && $urandom_range(1) == 1) begin
               rq[i] = 1'b1;
               dq[i] = {$urandom, $urandom};
            end
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
